// File: rtl/iro_seed_loader.sv
// Ring-oscillator seed loader: shifts a seed out on bclk/bdat, runs the oscillator
// for run_len cycles, freezes it with hold, then captures the synchronised phase taps.
module iro_seed_loader #(
  parameter int N_STAGES = 25,
  parameter int DIV      = 2,
  parameter int RUN_W    = 16,
  parameter int SETTLE   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_STAGES-1:0] seed_in,
  input  logic [RUN_W-1:0]    run_len,
  output logic                busy,
  output logic                bclk,
  output logic                bdat,
  output logic                enable,
  output logic                hold,
  input  logic [15:0]         phases,
  output logic [15:0]         cap_phases,
  output logic                cap_valid
);

  // state      | meaning
  // S_IDLE     | waiting for start, outputs quiet
  // S_SHIFT_LO | bclk low, bdat presents current seed bit
  // S_SHIFT_HI | bclk high, target samples bdat on the rise
  // S_RUN      | oscillator enabled for run_len cycles
  // S_HOLD     | oscillator frozen, waiting SETTLE cycles
  // S_CAPT     | cap_valid strobe with freshly captured phases
  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_RUN,
    S_HOLD,
    S_CAPT
  } state_t;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [DW-1:0]    DIV_TC  = DW'(DIV - 1);
  localparam logic [DW-1:0]    DIV_ONE = DW'(1);
  localparam logic [BW-1:0]    BIT_TC  = BW'(N_STAGES - 1);
  localparam logic [BW-1:0]    BIT_ONE = BW'(1);
  localparam logic [SW-1:0]    SET_TC  = SW'(SETTLE - 1);
  localparam logic [SW-1:0]    SET_ONE = SW'(1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_t              state_q, state_d;
  logic [N_STAGES-1:0] sh_q, sh_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [SW-1:0]       set_cnt_q, set_cnt_d;
  logic [15:0]         cap_q, cap_d;
  logic [15:0]         sync1_q, sync2_q;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    run_cnt_d = run_cnt_q;
    set_cnt_d = SET_TC;
    cap_d     = cap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d      = seed_in;
          run_cnt_d = run_len;
          bit_cnt_d = BIT_TC;
          div_cnt_d = DIV_TC;
          state_d   = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = DIV_TC;
          state_d   = S_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end
      end
      S_SHIFT_HI: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = DIV_TC;
          if (bit_cnt_q == '0) begin
            // zero run length goes straight to freeze
            state_d = (run_cnt_q == '0) ? S_HOLD : S_RUN;
          end else begin
            sh_d      = sh_q << 1;
            bit_cnt_d = bit_cnt_q - BIT_ONE;
            state_d   = S_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q - RUN_ONE;
        if (run_cnt_q == RUN_ONE) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (set_cnt_q == '0) begin
          // capture on the last hold edge so cap_phases is valid alongside cap_valid
          cap_d   = sync2_q;
          state_d = S_CAPT;
        end else begin
          set_cnt_d = set_cnt_q - SET_ONE;
        end
      end
      S_CAPT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      run_cnt_q <= '0;
      set_cnt_q <= SET_TC;
      cap_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      run_cnt_q <= run_cnt_d;
      set_cnt_q <= set_cnt_d;
      cap_q     <= cap_d;
      sync1_q   <= phases;
      sync2_q   <= sync1_q;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign bclk       = (state_q == S_SHIFT_HI);
  assign bdat       = ((state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI)) && sh_q[N_STAGES-1];
  assign enable     = (state_q == S_RUN) || (state_q == S_HOLD);
  assign hold       = (state_q == S_HOLD);
  assign cap_valid  = (state_q == S_CAPT);
  assign cap_phases = cap_q;

endmodule

// File: tb/tb_iro_seed_loader.sv
// Bench for iro_seed_loader: table of seed/run/phase vectors plus hand-written
// corner sequences, checked against a per-transaction behavioural model.
module tb_iro_seed_loader;
  localparam int N      = 25;
  localparam int DIV    = 2;
  localparam int RUN_W  = 16;
  localparam int SETTLE = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   seed_in = '0;
  logic [15:0]    run_len = '0;
  logic [15:0]    phases = '0;
  logic           busy, bclk, bdat, enable, hold, cap_valid;
  logic [15:0]    cap_phases;

  iro_seed_loader #(.N_STAGES(N), .DIV(DIV), .RUN_W(RUN_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in), .run_len(run_len),
    .busy(busy), .bclk(bclk), .bdat(bdat), .enable(enable), .hold(hold),
    .phases(phases), .cap_phases(cap_phases), .cap_valid(cap_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [N-1:0] seed;
    logic [15:0]  rl;
    logic [15:0]  ph;
    int           exp_busy;
    int           exp_en_run;
    int           exp_hold;
  } vec_t;

  typedef struct {
    int           rises;
    logic [N-1:0] tgt;
    int           gap_bad;
    int           setup_bad;
    int           hold_bad;
    int           en_shift;
    int           en_run;
    int           hold_n;
    int           capv;
    logic [15:0]  cap;
    int           busy_n;
    int           low_pre;
    int           timeout;
  } obs_t;

  // Drives one start, then watches the interface as the target would see it
  task automatic run_txn(input logic [N-1:0] seed, input logic [15:0] rl,
                         input bit keep_start, input bit intrude, output obs_t o);
    logic pb, pd;
    int   last_rise, last_chg;
    bit   done;
    o = '{rises: 0, tgt: '0, gap_bad: 0, setup_bad: 0, hold_bad: 0, en_shift: 0,
          en_run: 0, hold_n: 0, capv: 0, cap: '0, busy_n: 0, low_pre: 0, timeout: 0};
    seed_in = seed;
    run_len = rl;
    start   = 1'b1;
    pb = 1'b0; pd = 1'b0; last_rise = -1; last_chg = -1; done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
      end else begin
        o.busy_n++;
        if (bdat !== pd) begin
          last_chg = cyc;
          if (bclk) o.hold_bad++;
        end
        if (bclk && !pb) begin
          o.rises++;
          o.tgt = {o.tgt[N-2:0], bdat};
          if (last_rise >= 0 && (cyc - last_rise) != 2 * DIV) o.gap_bad++;
          if (cyc - last_chg < DIV) o.setup_bad++;
          last_rise = cyc;
        end
        if (o.rises == 0 && !bclk) o.low_pre++;
        if ((enable || hold) && o.rises < N) o.en_shift++;
        if (enable && !hold && o.hold_n == 0) o.en_run++;
        if (hold) o.hold_n++;
        if (cap_valid) begin
          o.capv++;
          o.cap = cap_phases;
        end
        pb = bclk;
        pd = bdat;
      end
      if (!keep_start && cyc == 0) start = 1'b0;
      if (intrude && cyc == 10) begin start = 1'b1; seed_in = ~seed; end
      if (intrude && cyc == 11) begin start = 1'b0; seed_in = seed; end
    end
    if (!done) o.timeout = 1;
  endtask

  task automatic check_txn(input string tag, input obs_t o, input vec_t v);
    check({tag, "_timeout"}, o.timeout, 0);
    check({tag, "_rises"}, o.rises, N);
    check({tag, "_target"}, 32'(o.tgt), 32'(v.seed));
    check({tag, "_gap"}, o.gap_bad, 0);
    check({tag, "_setup"}, o.setup_bad, 0);
    check({tag, "_bdat_hold"}, o.hold_bad, 0);
    check({tag, "_en_shift"}, o.en_shift, 0);
    check({tag, "_en_run"}, o.en_run, v.exp_en_run);
    check({tag, "_hold"}, o.hold_n, v.exp_hold);
    check({tag, "_capv"}, o.capv, 1);
    check({tag, "_cap"}, 32'(o.cap), 32'(v.ph));
    check({tag, "_busy"}, o.busy_n, v.exp_busy);
  endtask

  function automatic vec_t mk(input logic [N-1:0] s, input logic [15:0] r, input logic [15:0] p);
    vec_t v;
    v.seed       = s;
    v.rl         = r;
    v.ph         = p;
    v.exp_busy   = 2 * DIV * N + int'(r) + SETTLE + 1;
    v.exp_en_run = int'(r);
    v.exp_hold   = SETTLE;
    return v;
  endfunction

  vec_t vecs[10];
  obs_t o, o2;

  initial begin
    vecs[0] = mk(25'h1A5_5A5C, 16'd0, 16'hA5C3);
    vecs[1] = mk(25'h1A5_5A5C, 16'd10, 16'hA5C3);
    vecs[2] = mk(25'h000_0000, 16'd1, 16'hFFFF);
    vecs[3] = mk(25'h1FF_FFFF, 16'd3, 16'h0001);
    for (int i = 4; i < 10; i++)
      vecs[i] = mk(N'($urandom), 16'($urandom_range(0, 40)), 16'($urandom));

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_outs", {bclk, bdat, enable, hold, cap_valid}, 0);
    check("rst_cap", cap_phases, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      phases = vecs[i].ph;
      repeat (3) @(posedge clk);
      #1;
      run_txn(vecs[i].seed, vecs[i].rl, 1'b0, 1'b0, o);
      check_txn($sformatf("v%0d", i), o, vecs[i]);
    end

    // captured value must survive later phase activity
    phases = 16'hA5C3;
    repeat (3) @(posedge clk);
    #1;
    run_txn(25'h0F0_F0F0, 16'd5, 1'b0, 1'b0, o);
    check("cap_at_valid", o.cap, 16'hA5C3);
    phases = 16'h0000;
    repeat (10) @(posedge clk);
    #1;
    check("cap_held", cap_phases, 16'hA5C3);
    check("cap_no_strobe", cap_valid, 0);

    // start pulsed mid-shift with a different seed is ignored
    phases = 16'h3C5A;
    repeat (3) @(posedge clk);
    #1;
    run_txn(25'h155_AA33, 16'd7, 1'b0, 1'b1, o);
    check_txn("busy_ign", o, mk(25'h155_AA33, 16'd7, 16'h3C5A));
    repeat (20) @(posedge clk);
    #1;
    check("busy_ign_idle", busy, 0);

    // start held high: second load accepted in the cycle busy reads 0
    phases = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    run_txn(25'h0AB_CDEF, 16'd2, 1'b1, 1'b0, o);
    check_txn("b2b_a", o, mk(25'h0AB_CDEF, 16'd2, 16'h1234));
    run_txn(25'h13579BD, 16'd4, 1'b0, 1'b0, o2);
    check_txn("b2b_b", o2, mk(25'h13579BD, 16'd4, 16'h1234));
    check("b2b_bclk_low", o2.low_pre >= DIV, 1);

    // asynchronous reset in the middle of RUN
    phases = 16'hBEEF;
    seed_in = 25'h1234567;
    run_len = 16'd300;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check("mid_run_enable", enable, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {busy, bclk, bdat, enable, hold, cap_valid}, 0);
    check("async_rst_cap", cap_phases, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int strobes = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (cap_valid || busy) strobes++;
      end
      check("post_abort_quiet", strobes, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
